wide_add_sequencer: RTL and testbench

Multi-cycle controller that shares one external 32-bit carry-select adder slice between two requesters to perform WORDS×32-bit additions. It arbitrates round-robin, latches the winner's operands, and steps the adder across the words LSW first. Between steps it carries the slice carry-out into the next word's carry-in, then returns the full sum on a valid/ready response port. It sits between wide-arithmetic clients and the shared 32-bit adder datapath, which stays purely combinational.

---
 rtl/wide_add_sequencer.sv | 106 ++++++++++
 tb/tb_wide_add_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Shares one combinational 32-bit adder slice between two requesters, stepping
// WORDS-wide additions LSW first and returning the sum on a valid/ready port.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [32*WORDS-1:0] req0_a,
    input  logic [32*WORDS-1:0] req0_b,
    input  logic                req0_cin,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [32*WORDS-1:0] req1_a,
    input  logic [32*WORDS-1:0] req1_b,
    input  logic                req1_cin,
    output logic                req1_ready,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic                add_cin,
    input  logic [31:0]         add_sum,
    input  logic                add_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [32*WORDS-1:0] rsp_sum,
    output logic                rsp_cout,
    output logic                rsp_id,
    output logic                busy
);
    localparam int W  = 32 * WORDS;
    localparam int KW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_reg, b_reg, sum_reg;
    logic            cin_reg, carry_reg, id_reg;
    logic            ptr;        // 0 favours req0, 1 favours req1
    logic [KW-1:0]   k;
    logic            grant0, grant1, accept, last_word;

    assign grant0    = req0_valid && (!req1_valid || !ptr);
    assign grant1    = req1_valid && (!req0_valid || ptr);
    assign last_word = (k == KW'(WORDS - 1));

    // Ready is held low during reset even though the state register reads IDLE.
    assign req0_ready = (state == IDLE) && !rst && grant0;
    assign req1_ready = (state == IDLE) && !rst && grant1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_nxt = state;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                add_a   = a_reg[32*k +: 32];
                add_b   = b_reg[32*k +: 32];
                add_cin = (k == '0) ? cin_reg : carry_reg;
                if (last_word) state_nxt = DONE;
            end
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            id_reg    <= 1'b0;
            ptr       <= 1'b0;
            k         <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_reg   <= req1_ready ? req1_a   : req0_a;
                    b_reg   <= req1_ready ? req1_b   : req0_b;
                    cin_reg <= req1_ready ? req1_cin : req0_cin;
                    id_reg  <= req1_ready;
                    ptr     <= !req1_ready;   // next contention favours the loser
                    k       <= '0;
                end
                RUN: begin
                    sum_reg[32*k +: 32] <= add_sum;
                    carry_reg           <= add_cout;
                    k                   <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = rsp_valid ? sum_reg : '0;
    assign rsp_cout  = rsp_valid && carry_reg;
    assign rsp_id    = rsp_valid && id_reg;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed vectors, multi-cycle corner sequences and a randomized scoreboard
// run for wide_add_sequencer with WORDS=4.
module tb_wide_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_cin, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_cin, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [31:0]  add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_id, busy;
    logic [W-1:0] rsp_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // the shared external slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
    );

    typedef struct {
        bit           id;
        logic [W-1:0] a, b;
        bit           cin;
        logic [W-1:0] sum;
        bit           cout;
    } vec_t;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, b, input bit cin);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    task automatic set_req(input bit id, input bit v, input logic [W-1:0] a, b, input bit cin);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present a request and wait for its ready; returns just after the accepting edge.
    task automatic issue(input bit id, input logic [W-1:0] a, b, input bit cin);
        int n = 0;
        set_req(id, 1'b1, a, b, cin);
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        set_req(id, 1'b0, '0, '0, 1'b0);
    endtask

    // Called just after the accepting edge: counts cycles to rsp_valid, checks, consumes.
    task automatic wait_rsp(input bit id, input logic [W:0] exp);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        chk("latency", n, WORDS + 1);
        chk("rsp_sum", {rsp_cout, rsp_sum}, exp);
        chk("rsp_id", rsp_id, id);
        chk("busy_done", busy, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    vec_t vecs[5];
    logic [W-1:0] ra [2];
    logic [W-1:0] rb [2];
    bit           rc [2];
    bit           rv [2];

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return {4{32'hFFFF_FFFF}} >> (32 * $urandom_range(0, 3));
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);

        // Reset state, with both requesters asserting valid during reset
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {rsp_valid, rsp_cout, rsp_id, busy, rsp_sum},
            {4'b0, {W{1'b0}}});
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        chk("reset_add", {add_cin, add_a, add_b}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Directed vectors
        vecs[0] = '{0, '1, 128'd1, 0, '0, 1};
        vecs[1] = '{1, '0, '0, 1, 128'd1, 0};
        vecs[2] = '{0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 0,
                    128'h0000_0000_0000_0000_0000_0001_0000_0000, 0};
        vecs[3] = '{1, '1, '1, 1, '1, 1};
        vecs[4] = '{0, {4{32'h8000_0000}}, {4{32'h8000_0000}}, 0,
                    128'h0000_0001_0000_0001_0000_0001_0000_0000, 1};
        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_rsp(vecs[i].id, {vecs[i].cout, vecs[i].sum});
        end

        // Contention: both valid continuously from reset
        begin
            logic [W-1:0] ca [2];
            logic [W-1:0] cb [2];
            int grants = 0, rsps = 0, n = 0;
            bit p0 = 0, p1 = 0;
            ca[0] = {4{32'h1234_5678}}; cb[0] = {4{32'hF0F0_F0F0}};
            ca[1] = '1;                 cb[1] = 128'd5;
            do_reset();
            set_req(0, 1'b1, ca[0], cb[0], 1'b0);
            set_req(1, 1'b1, ca[1], cb[1], 1'b1);
            rsp_ready = 1'b1;
            while (rsps < 4 && n < 80) begin
                @(negedge clk); n++;
                chk("cont_mutex", req0_ready & req1_ready, 0);
                if (req0_ready || req1_ready) begin
                    chk("cont_order", req1_ready, grants % 2);
                    chk("cont_pulse", (req0_ready & p0) | (req1_ready & p1), 0);
                    grants++;
                end
                if (rsp_valid) begin
                    chk("cont_id", rsp_id, rsps % 2);
                    chk("cont_sum", {rsp_cout, rsp_sum},
                        ref_add(ca[rsps % 2], cb[rsps % 2], (rsps % 2) == 1));
                    rsps++;
                end
                p0 = req0_ready; p1 = req1_ready;
            end
            if (rsps < 4) chk("cont_timeout", rsps, 4);
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            set_req(0, 1'b0, '0, '0, 1'b0);
            set_req(1, 1'b0, '0, '0, 1'b0);
        end

        // Backpressure: hold rsp_ready low in DONE with req0 waiting
        begin
            logic [W+2:0] snap;
            int n = 0;
            do_reset();
            @(negedge clk);
            issue(0, {4{32'hDEAD_BEEF}}, {4{32'h2152_4111}}, 1'b1);
            set_req(0, 1'b1, 128'd7, 128'd9, 1'b0);
            do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
            chk("bp_sum", {rsp_cout, rsp_sum},
                ref_add({4{32'hDEAD_BEEF}}, {4{32'h2152_4111}}, 1'b1));
            snap = {rsp_valid, rsp_id, rsp_cout, rsp_sum};
            repeat (3) begin
                chk("bp_stable", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, snap);
                chk("bp_no_ready", req0_ready, 0);
                @(negedge clk);
            end
            rsp_ready = 1'b1; #1;
            chk("bp_hs_no_ready", req0_ready, 0);
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("bp_accept_next", req0_ready, 1);
            @(posedge clk); #1;
            set_req(0, 1'b0, '0, '0, 1'b0);
            wait_rsp(0, 129'd16);
        end

        // Reset while k=2
        begin
            logic [W-1:0] a = 128'h0000_0003_0000_0002_0000_0001_0000_0000;
            @(negedge clk);
            issue(1, a, '1, 1'b0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("mid_word2", add_a, 32'h0000_0002);
            @(negedge clk);
            rst = 1'b1; req0_valid = 1'b1;
            @(posedge clk); #1;
            chk("mid_rst_state", {busy, rsp_valid, req0_ready}, 0);
            chk("mid_rst_add", {add_cin, add_a, add_b}, 0);
            @(negedge clk);
            rst = 1'b0; req0_valid = 1'b0;
            repeat (10) begin
                @(negedge clk);
                chk("mid_no_stale", {rsp_valid, busy}, 0);
            end
            issue(0, 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0001, 128'h1_FFFF_FFFF, 1'b1);
            wait_rsp(0, ref_add(128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0001,
                                128'h1_FFFF_FFFF, 1'b1));
        end

        // Randomized traffic against a transaction-level model
        begin
            logic [W+1:0] exp_q[$];
            logic [W+1:0] got, snap;
            bit mptr = 0, inflight = 0, hold = 0, g0, g1, hs;
            int since = 0;
            do_reset();
            for (int i = 0; i < 2; i++) begin
                rv[i] = 0; ra[i] = '0; rb[i] = '0; rc[i] = 0;
            end
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(negedge clk);
                if (inflight) since++;
                g0 = !inflight && rv[0] && (!rv[1] || !mptr);
                g1 = !inflight && rv[1] && (!rv[0] || mptr);
                chk("rnd_ready", {req1_ready, req0_ready}, {g1, g0});
                chk("rnd_valid", rsp_valid, inflight && since >= WORDS + 1);
                got = {rsp_id, rsp_cout, rsp_sum};
                if (hold && rsp_valid) chk("rnd_stable", got, snap);
                hs = rsp_valid && rsp_ready;
                if (hs) begin
                    if (exp_q.size() == 0) chk("rnd_unexpected", 1, 0);
                    else chk("rnd_rsp", got, exp_q.pop_front());
                end
                hold = rsp_valid && !rsp_ready;
                snap = got;
                if (g0 || g1) begin
                    exp_q.push_back({g1, ref_add(ra[g1], rb[g1], rc[g1])});
                    mptr = !g1;
                    inflight = 1; since = 0;
                end
                if (hs) inflight = 0;
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    if ((i == 0 && g0) || (i == 1 && g1) || !rv[i]) begin
                        rv[i] = ($urandom_range(0, 2) != 0);
                        ra[i] = rand_word(); rb[i] = rand_word(); rc[i] = $urandom_range(0, 1);
                    end
                    set_req(i[0], rv[i], ra[i], rb[i], rc[i]);
                end
                rsp_ready = ($urandom_range(0, 2) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
